// File: rtl/timer_loader.sv
// Keypad-to-timer loader: debounces a one-hot decimal keypad and shifts each
// accepted digit into the downstream timer with a single active-low strobe.
module timer_loader #(
   parameter int unsigned DEBOUNCE_CYCLES = 4
) (
   input  logic       clk,
   input  logic       clearn,
   input  logic [9:0] keypad,
   input  logic       lock,
   input  logic       cancel,
   output logic [3:0] bcd_output,
   output logic       loadn,
   output logic [1:0] digit_count,
   output logic       full,
   output logic       err
);

   localparam int unsigned KEY_W = 10;
   localparam int unsigned CNT_W = 8;
   localparam int unsigned DIG_W = 4;

   localparam logic [1:0] IDLE         = 2'd0;
   localparam logic [1:0] DEBOUNCE     = 2'd1;
   localparam logic [1:0] LOAD         = 2'd2;
   localparam logic [1:0] WAIT_RELEASE = 2'd3;

   logic [1:0]       state_q, state_d;
   logic [KEY_W-1:0] code_q, code_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [DIG_W-1:0] bcd_q, bcd_d;
   logic [DIG_W-1:0] shadow_q, shadow_d;
   logic [1:0]       count_q, count_d;
   logic             loadn_q, loadn_d;
   logic             full_q, full_d;
   logic             err_q, err_d;

   logic             key_valid;
   logic             reject;
   logic [DIG_W-1:0] key_idx;

   // Exactly one key down; zero is a release, several is an invalid chord.
   assign key_valid = (keypad != '0) && ((keypad & (keypad - KEY_W'(1))) == '0);

   // A units digit above 5 cannot be shifted into the mod-6 tens-of-seconds stage.
   assign reject = full_q || ((count_q != 2'd0) && (shadow_q > DIG_W'(5)));

   always_comb begin
      key_idx = '0;
      for (int unsigned i = 0; i < KEY_W; i++) begin
         if (code_q[i]) key_idx = DIG_W'(i);
      end
   end

   always_comb begin
      state_d  = state_q;
      code_d   = code_q;
      cnt_d    = cnt_q;
      bcd_d    = bcd_q;
      shadow_d = shadow_q;
      count_d  = count_q;
      full_d   = full_q;
      loadn_d  = 1'b1;
      err_d    = 1'b0;

      case (state_q)
         IDLE: begin
            if (!lock && key_valid) begin
               code_d  = keypad;
               cnt_d   = '0;
               state_d = DEBOUNCE;
            end
         end
         DEBOUNCE: begin
            if (lock || (keypad != code_q)) begin
               state_d = IDLE;
            end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES)) begin
               if (reject) begin
                  err_d   = 1'b1;
                  state_d = WAIT_RELEASE;
               end else begin
                  loadn_d = 1'b0;
                  bcd_d   = key_idx;
                  state_d = LOAD;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         LOAD: begin
            // LOAD is only entered when not full, so the increment cannot wrap.
            count_d  = count_q + 2'd1;
            full_d   = (count_q == 2'd2);
            shadow_d = bcd_q;
            state_d  = lock ? IDLE : WAIT_RELEASE;
         end
         WAIT_RELEASE: begin
            if (lock || (keypad == '0)) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Cancel wins over everything; a strobe already on the wire still finishes.
      if (cancel) begin
         count_d  = '0;
         full_d   = 1'b0;
         shadow_d = '0;
         bcd_d    = bcd_q;
         loadn_d  = 1'b1;
         err_d    = 1'b0;
         state_d  = IDLE;
      end
   end

   always_ff @(posedge clk or negedge clearn) begin
      if (!clearn) begin
         state_q  <= IDLE;
         code_q   <= '0;
         cnt_q    <= '0;
         bcd_q    <= '0;
         shadow_q <= '0;
         count_q  <= '0;
         loadn_q  <= 1'b1;
         full_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         code_q   <= code_d;
         cnt_q    <= cnt_d;
         bcd_q    <= bcd_d;
         shadow_q <= shadow_d;
         count_q  <= count_d;
         loadn_q  <= loadn_d;
         full_q   <= full_d;
         err_q    <= err_d;
      end
   end

   assign bcd_output  = bcd_q;
   assign loadn       = loadn_q;
   assign digit_count = count_q;
   assign full        = full_q;
   assign err         = err_q;

endmodule
